// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO read controllers: state encodings and the
// parameter consistency rule for grant index width.
package fifo_read_arbiter_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'b00,
        GRANT  = 2'b01,
        UPDATE = 2'b10
    } state_t;

    function automatic bit id_w_matches(input int unsigned num_req, input int unsigned id_w);
        return (id_w == $clog2(num_req)) && (num_req >= 2) && (num_req <= 16);
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_priority_picker.sv
// Round-robin picker: finds the first set request at or after last_ptr+1,
// wrapping, by rotating, priority-encoding and un-rotating.
module rr_priority_picker
    import fifo_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    int unsigned         start_pos;
    int unsigned         pos;
    logic [NUM_REQ-1:0]  rot;

    always_comb begin
        start_pos = (32'(last_ptr) + 32'd1) % NUM_REQ;
        // rot[0] is the request at start_pos; the left shift is zero when start_pos is 0
        rot   = (req >> start_pos) | (req << (NUM_REQ - start_pos));
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end
        idx = ID_W'((start_pos + pos) % NUM_REQ);
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares one FIFO read port among NUM_REQ consumers with round-robin grants;
// pulses r_cnt once after each completed read to advance the read pointer.
module fifo_read_arbiter
    import fifo_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] r_en,
    input  logic               empty,
    output logic [NUM_REQ-1:0] valid,
    output logic               r_cnt,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy
);

    if (!id_w_matches(NUM_REQ, ID_W)) begin : g_param_check
        $error("fifo_read_arbiter: ID_W must equal clog2(NUM_REQ), NUM_REQ in 2..16");
    end

    state_t          state;
    state_t          next_state;
    logic [ID_W-1:0] last_ptr;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            load_grant;
    logic            cur_req;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req      (r_en),
        .last_ptr (last_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        next_state = state;
        valid      = '0;
        r_cnt      = 1'b0;
        busy       = 1'b0;
        load_grant = 1'b0;
        cur_req    = |(r_en & (NUM_REQ'(1) << grant_id));
        case (state)
            IDLE: begin
                if (!empty && pick_found) begin
                    next_state = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                busy  = 1'b1;
                valid = NUM_REQ'(1) << grant_id;
                if (!cur_req) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                busy       = 1'b1;
                r_cnt      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            last_ptr <= ID_W'(NUM_REQ - 1);
        end else begin
            state <= next_state;
            if (load_grant) begin
                grant_id <= pick_idx;
            end
            if (state == UPDATE) begin
                last_ptr <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter with a transaction-level reference
// model compared against the outputs on every falling edge.
module tb_fifo_read_arbiter;
    import fifo_read_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] r_en;
    logic               empty;
    logic [NUM_REQ-1:0] valid;
    logic               r_cnt;
    logic [ID_W-1:0]    grant_id;
    logic               busy;

    fifo_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r_en     (r_en),
        .empty    (empty),
        .valid    (valid),
        .r_cnt    (r_cnt),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rcnt_count = 0;
    bit skip_cmp = 1'b0;
    bit hold_model = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: who owns the head, whether the owner has released, and
    // the last completed grantee for the round-robin scan.
    int m_owner;
    bit m_rel;
    int m_last;
    int m_gid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_rel   = 1'b0;
            m_last  = NUM_REQ - 1;
            m_gid   = 0;
        end else if (hold_model) begin
            m_owner = -1;
            m_rel   = 1'b0;
        end else if (m_rel) begin
            m_last  = m_owner;
            m_owner = -1;
            m_rel   = 1'b0;
        end else if (m_owner >= 0) begin
            if ((r_en & (4'b0001 << m_owner)) == 4'b0000) m_rel = 1'b1;
        end else if (!empty) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_last + k) % NUM_REQ;
                if (m_owner < 0 && (r_en & (4'b0001 << c)) != 4'b0000) begin
                    m_owner = c;
                    m_gid   = c;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !skip_cmp) begin
            logic [NUM_REQ-1:0] exp_valid;
            exp_valid = (m_owner >= 0 && !m_rel) ? (4'b0001 << m_owner) : 4'b0000;
            chk("model_valid", 32'(valid), 32'(exp_valid));
            chk("model_r_cnt", 32'(r_cnt), 32'(m_rel));
            chk("model_busy", 32'(busy), 32'(m_owner >= 0));
            chk("model_grant_id", 32'(grant_id), 32'(m_gid));
        end
        if (r_cnt) rcnt_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int n;
        int order[5];
        int gcyc[5];
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        // Reset then single requester 2
        rst = 1'b1; r_en = '0; empty = 1'b0;
        #2;
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_r_cnt", 32'(r_cnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_grant_id", 32'(grant_id), 32'h0);
        tick();
        rst = 1'b0;
        r_en = 4'b0100;
        tick(); chk("single_valid1", 32'(valid), 32'h4); chk("single_gid", 32'(grant_id), 32'h2);
        tick(); chk("single_valid2", 32'(valid), 32'h4);
        tick(); chk("single_valid3", 32'(valid), 32'h4); chk("single_busy3", 32'(busy), 32'h1);
        r_en = 4'b0000;
        tick(); chk("single_rcnt", 32'(r_cnt), 32'h1); chk("single_valid_off", 32'(valid), 32'h0);
        chk("single_busy4", 32'(busy), 32'h1);
        tick(); chk("single_idle_busy", 32'(busy), 32'h0); chk("single_rcnt_off", 32'(r_cnt), 32'h0);
        chk("single_gid_hold", 32'(grant_id), 32'h2);

        // Round-robin fairness from reset
        do_reset();
        rc0 = rcnt_count;
        r_en = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (valid == '0 && n < 10) begin
                tick();
                n++;
            end
            if (valid == '0) begin
                checks++; errors++;
                $display("FAIL rr_wait: got no grant expected a grant within 10 cycles");
            end
            order[g] = int'(grant_id);
            gcyc[g]  = cyc;
            r_en = 4'b1111 & ~valid;
            tick();
            r_en = (g == 4) ? 4'b0000 : 4'b1111;
        end
        tick(); tick();
        for (int g = 0; g < 5; g++) chk("rr_order", 32'(order[g]), 32'(exp_order[g]));
        for (int g = 1; g < 5; g++) chk("rr_spacing", 32'(gcyc[g] - gcyc[g-1]), 32'd3);
        chk("rr_rcnt_count", 32'(rcnt_count - rc0), 32'd5);

        // Empty gating
        do_reset();
        empty = 1'b1; r_en = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("empty_valid", 32'(valid), 32'h0);
            chk("empty_r_cnt", 32'(r_cnt), 32'h0);
            chk("empty_busy", 32'(busy), 32'h0);
        end
        empty = 1'b0;
        tick(); chk("unempty_valid", 32'(valid), 32'h1); chk("unempty_gid", 32'(grant_id), 32'h0);
        r_en = 4'b0010;
        tick(); chk("unempty_rcnt", 32'(r_cnt), 32'h1);
        tick();
        tick(); chk("grant1_valid", 32'(valid), 32'h2); chk("grant1_gid", 32'(grant_id), 32'h1);

        // Empty rising during GRANT is ignored
        empty = 1'b1;
        tick(); chk("empty_mid_valid1", 32'(valid), 32'h2);
        tick(); chk("empty_mid_valid2", 32'(valid), 32'h2);
        rc0 = rcnt_count;
        r_en = 4'b0000;
        tick(); chk("empty_mid_rcnt", 32'(r_cnt), 32'h1);
        tick(); chk("empty_mid_idle", 32'(busy), 32'h0);
        tick(); chk("empty_mid_rcnt_once", 32'(rcnt_count - rc0), 32'd1);
        empty = 1'b0;

        // Async reset mid-GRANT
        r_en = 4'b1000;
        tick(); chk("pre_rst_valid", 32'(valid), 32'h8); chk("pre_rst_gid", 32'(grant_id), 32'h3);
        rc0 = rcnt_count;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_r_cnt", 32'(r_cnt), 32'h0);
        chk("arst_gid", 32'(grant_id), 32'h0);
        r_en = 4'b1001;
        tick();
        rst = 1'b0;
        tick(); chk("post_rst_valid", 32'(valid), 32'h1); chk("post_rst_gid", 32'(grant_id), 32'h0);
        chk("arst_no_rcnt", 32'(rcnt_count - rc0), 32'd0);
        r_en = 4'b0000;
        tick(); tick();

        // Wrap: last grant 3, then 0 wins over 3
        r_en = 4'b1000;
        tick(); chk("wrap_pre_gid", 32'(grant_id), 32'h3);
        r_en = 4'b0000;
        tick(); tick();
        r_en = 4'b1001;
        tick(); chk("wrap_valid", 32'(valid), 32'h1); chk("wrap_gid", 32'(grant_id), 32'h0);
        r_en = 4'b0000;
        tick(); tick();

        // Illegal state encoding
        skip_cmp = 1'b1;
        hold_model = 1'b1;
        r_en = 4'b1111;
        force dut.state = state_t'(2'b11);
        #1;
        chk("illegal_valid", 32'(valid), 32'h0);
        chk("illegal_r_cnt", 32'(r_cnt), 32'h0);
        chk("illegal_busy", 32'(busy), 32'h0);
        #1;
        release dut.state;
        tick();
        chk("illegal_next_idle", 32'(dut.state), 32'(IDLE));
        chk("illegal_next_busy", 32'(busy), 32'h0);
        hold_model = 1'b0;
        r_en = 4'b0000;
        skip_cmp = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
